// File: rtl/spi_flash_boot_loader_pkg.sv
// boot_loader_pkg: state encoding and constants shared by the SPI flash boot loader.
package boot_loader_pkg;
  typedef enum logic [2:0] {IDLE, CMD, READ, WB_WR, DONE, ERROR} boot_state_t;
  localparam logic [7:0] SPI_READ_CMD = 8'h03;
  localparam logic [7:0] WB_TIMEOUT_CYCLES = 8'd255;
  // Flash delivers the image byte-serially, so the first byte received lands in the low lane.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-0 SPI shifter, 32 bits per start, SCK half-period of CLK_DIV clk cycles.
module spi_shift_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] tx_word,
  output logic [31:0] rx_word,
  output logic        busy,
  output logic        done,
  output logic        sck_o,
  output logic        mosi_o,
  input  logic        miso_i
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic [30:0] tx;
  logic [4:0] bits;
  logic tick;
  assign tick = div == DW'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (!reset_n) begin
      div <= '0;
      tx <= '0;
      bits <= '0;
      rx_word <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sck_o <= 1'b0;
      mosi_o <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        tx <= tx_word[30:0];
        mosi_o <= tx_word[31];
        sck_o <= 1'b0;
        div <= '0;
        bits <= '0;
      end else if (busy) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) begin
          sck_o <= !sck_o;
          if (!sck_o) rx_word <= {rx_word[30:0], miso_i};
          else begin
            // MOSI advances only on the falling edge so it is stable across the next rise.
            bits <= bits + 1'b1;
            tx <= {tx[29:0], 1'b0};
            mosi_o <= bits == 5'd31 ? 1'b0 : tx[30];
            busy <= bits != 5'd31;
            done <= bits == 5'd31;
          end
        end
      end
    end
endmodule

// File: rtl/spi_flash_boot_loader.sv
// spi_flash_boot_loader: copies BOOT_WORDS words from SPI flash into IMEM over Wishbone, then releases the core.
// Optional WB_WR watchdog enabled by defining BOOT_WB_TIMEOUT_EN.
module spi_flash_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int          CLK_DIV    = 4,
  parameter int          BOOT_WORDS = 128,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        sck_o,
  output logic        ss_o,
  output logic        mosi_o,
  input  logic        miso_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        core_reset_n,
  output logic        boot_done,
  output logic        boot_err
);
  localparam int CW = BOOT_WORDS > 1 ? $clog2(BOOT_WORDS) : 1;
  boot_state_t state;
  logic [CW-1:0] count;
  logic start, busy, done, timeout;
  logic [31:0] tx_word, rx_word;
`ifdef BOOT_WB_TIMEOUT_EN
  logic [7:0] wd;
  assign timeout = wd == WB_TIMEOUT_CYCLES - 8'd1;
`else
  assign timeout = 1'b0;
`endif
  // The command is loaded on the IDLE->CMD edge; each READ word starts once the engine is free.
  assign start = state == IDLE || (state == READ && !busy && !done);
  assign tx_word = state == IDLE ? {SPI_READ_CMD, FLASH_BASE} : '0;
  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .tx_word(tx_word),
    .rx_word(rx_word),
    .busy(busy),
    .done(done),
    .sck_o(sck_o),
    .mosi_o(mosi_o),
    .miso_i(miso_i)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      ss_o <= 1'b1;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      core_reset_n <= 1'b0;
      boot_done <= 1'b0;
      boot_err <= 1'b0;
`ifdef BOOT_WB_TIMEOUT_EN
      wd <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= CMD;
          ss_o <= 1'b0;
        end
        CMD: if (done) state <= READ;
        READ: if (done) begin
          state <= WB_WR;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o <= 1'b1;
          wb_sel_o <= 4'hF;
          wb_adr_o <= IMEM_BASE + (32'(count) << 2);
          wb_dat_o <= bswap32(rx_word);
`ifdef BOOT_WB_TIMEOUT_EN
          wd <= '0;
`endif
        end
        WB_WR: if (wb_ack_i || wb_err_i || timeout) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o <= 1'b0;
          wb_sel_o <= 4'h0;
          // An error (or a stalled slave) wins over a simultaneous ack.
          if (wb_err_i || timeout) begin
            state <= ERROR;
            ss_o <= 1'b1;
            boot_err <= 1'b1;
          end else if (count == CW'(BOOT_WORDS - 1)) begin
            state <= DONE;
            ss_o <= 1'b1;
            core_reset_n <= 1'b1;
            boot_done <= 1'b1;
          end else begin
            count <= count + 1'b1;
            state <= READ;
          end
        end
`ifdef BOOT_WB_TIMEOUT_EN
        else wd <= wd + 8'd1;
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// tb_spi_flash_boot_loader: directed checks of the boot loader against a flash model and a Wishbone slave model.
module tb_spi_flash_boot_loader;
  localparam int CLK_DIV = 2;
  localparam int BOOT_WORDS = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sck, ss, mosi, miso;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0] wb_sel;
  logic wb_we, wb_cyc, wb_stb;
  logic ack = 1'b0;
  logic err = 1'b0;
  logic core_reset_n, boot_done, boot_err;
  logic [12:0] outs;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  spi_flash_boot_loader #(.CLK_DIV(CLK_DIV), .BOOT_WORDS(BOOT_WORDS), .FLASH_BASE(24'h010000), .IMEM_BASE(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .sck_o(sck), .ss_o(ss), .mosi_o(mosi), .miso_i(miso),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat), .wb_sel_o(wb_sel), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc),
    .wb_stb_o(wb_stb), .wb_ack_i(ack), .wb_err_i(err), .core_reset_n(core_reset_n),
    .boot_done(boot_done), .boot_err(boot_err)
  );
  assign outs = {sck, ss, mosi, wb_cyc, wb_stb, wb_we, wb_sel, core_reset_n, boot_done, boot_err};
  logic [7:0] image [16] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                             8'h13, 8'h01, 8'h20, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00};
  logic [31:0] exp_w [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h0000006f};
  // Flash model: captures the 32-bit command, then streams the image MSB-first.
  int cap = 0, rbit = 0, frames = 0;
  logic [31:0] cmd = '0;
  always @(posedge sck or posedge ss)
    if (ss) begin
      cap = 0;
      rbit = 0;
    end else if (cap < 32) begin
      cmd = {cmd[30:0], mosi};
      cap++;
      if (cap == 32) frames++;
    end else rbit++;
  assign miso = (!ss && cap >= 32) ? image[(rbit / 8) % 16][7 - rbit % 8] : 1'b0;
  // Wishbone slave model: logs accepted writes, checks stability while strobed.
  int cnt = 0, nw = 0, unstable = 0, sck_hi = 0;
  int slow_word = -1, err_word = -1;
  logic both = 1'b0, never_ack = 1'b0;
  logic [31:0] adr0, dat0;
  logic [31:0] log_adr [64], log_dat [64];
  int log_len [64];
  always @(negedge clk)
    if (wb_stb && wb_cyc) begin
      cnt++;
      if (cnt == 1) begin
        adr0 = wb_adr;
        dat0 = wb_dat;
      end
      if (wb_adr !== adr0 || wb_dat !== dat0 || wb_sel !== 4'hF || wb_we !== 1'b1) unstable++;
      if (sck) sck_hi++;
      if (!never_ack && cnt == ((int'(wb_adr >> 2) == slow_word) ? 6 : 1)) begin
        if (int'(wb_adr >> 2) == err_word) begin
          err = 1'b1;
          ack = both;
        end else begin
          ack = 1'b1;
          if (nw < 64) begin
            log_adr[nw] = wb_adr;
            log_dat[nw] = wb_dat;
            log_len[nw] = cnt;
          end
          nw++;
        end
      end
    end else begin
      cnt = 0;
      ack = 1'b0;
      err = 1'b0;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic restart();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic wait_end(input int limit);
    int n = 0;
    while (!boot_done && !boot_err && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int n, base, f0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs), 32'h800);
    chk("reset_adr", wb_adr, 32'h0);
    chk("reset_dat", wb_dat, 32'h0);
    slow_word = 1;
    reset_n = 1'b1;
    n = 0;
    while (ss && n < 8) begin @(negedge clk); n++; end
    chk("ss_fall", 32'(ss), 32'h0);
    chk("cmd_mosi_msb", 32'(mosi), 32'h0);
    n = 0;
    while (!sck && n < 100) begin @(negedge clk); n++; end
    chk("first_rise_delay", n, CLK_DIV);
    n = 0;
    while (sck && n < 100) begin @(negedge clk); n++; end
    chk("sck_high_phase", n, CLK_DIV);
    n = 0;
    while (!sck && n < 100) begin @(negedge clk); n++; end
    chk("sck_low_phase", n, CLK_DIV);
    wait_end(5000);
    chk("done_outs", 32'(outs), 32'h806);
    chk("cmd_frame", cmd, 32'h03010000);
    chk("nwrites", nw, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr_adr", log_adr[i], 32'(i * 4));
      chk("wr_dat", log_dat[i], exp_w[i]);
    end
    chk("slow_stb_len", log_len[1], 6);
    chk("fast_stb_len", log_len[0], 1);
    chk("wb_unstable", unstable, 0);
    chk("sck_during_stb", sck_hi, 0);
    slow_word = -1;
    err_word = 2;
    base = nw;
    restart();
    wait_end(5000);
    chk("err_outs", 32'(outs), 32'h801);
    chk("err_nwrites", nw - base, 2);
    chk("err_last_adr", log_adr[nw - 1], 32'h4);
    err_word = 1;
    both = 1'b1;
    base = nw;
    restart();
    wait_end(5000);
    chk("ackerr_outs", 32'(outs), 32'h801);
    chk("ackerr_nwrites", nw - base, 1);
    err_word = -1;
    both = 1'b0;
    base = nw;
    restart();
    n = 0;
    while (nw - base < 1 && n < 5000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("midread_ss_low", 32'(ss), 32'h0);
    f0 = frames;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_outs", 32'(outs), 32'h800);
    chk("midreset_dat", wb_dat, 32'h0);
    reset_n = 1'b1;
    base = nw;
    wait_end(5000);
    chk("restart_done", 32'(boot_done), 32'h1);
    chk("restart_frames", frames - f0, 1);
    chk("restart_cmd", cmd, 32'h03010000);
    chk("restart_nwrites", nw - base, 4);
    chk("restart_first_adr", log_adr[base], 32'h0);
    chk("restart_first_dat", log_dat[base], exp_w[0]);
    never_ack = 1'b1;
    restart();
    n = 0;
    while (!wb_stb && n < 2000) begin @(negedge clk); n++; end
    chk("wd_stb_rise", 32'(wb_stb), 32'h1);
    n = 0;
`ifdef BOOT_WB_TIMEOUT_EN
    while (!boot_err && n < 400) begin @(negedge clk); n++; end
    chk("wd_cycles", n, 255);
    chk("wd_outs", 32'(outs), 32'h801);
`else
    repeat (1000) @(negedge clk);
    chk("nowd_stb", 32'(wb_stb), 32'h1);
    chk("nowd_err", 32'(boot_err), 32'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_flash_boot_loader.md
Name: spi_flash_boot_loader

Overview:
- Wishbone master that copies a program image from external SPI flash into IMEM after reset.
- Sits upstream of the instruction memory. It is a second master on the Wishbone path, next to the core's wishbone_controller.
- Holds the core in reset until the copy finishes, then releases it.
- Uses one continuous SPI READ (0x03) transaction. SCK pauses while each word is written over Wishbone.

Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles; must be >= 1.
- BOOT_WORDS, 128: number of 32-bit words copied; matches IMEM_DEPTH.
- FLASH_BASE, 24'h000000: flash byte address of the image.
- IMEM_BASE, 32'h0000_0000: Wishbone byte address of IMEM word 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- sck_o  out  1  SPI clock, mode 0, idles low
- ss_o  out  1  flash chip select, active low
- mosi_o  out  1  serial data to flash
- miso_i  in  1  serial data from flash
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  byte select, always 4'hF when strobing
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error
- core_reset_n  out  1  reset to rv32i_top, active low
- boot_done  out  1  copy complete
- boot_err  out  1  copy aborted

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-low (reset_n sampled on posedge clk).
- Reset values: sck_o=0, ss_o=1, mosi_o=0, all wb_* outputs=0, core_reset_n=0, boot_done=0, boot_err=0. Word counter=0, FSM=IDLE.
- Reset mid-operation: on the first clock edge with reset_n=0, all outputs return to reset values and ss_o=1, which terminates the flash transaction. After release, the copy restarts from word 0.
- SPI timing, mode 0:
  - mosi_o changes only while sck_o is low; miso_i is sampled on the clk edge that drives sck_o high.
  - Each SCK phase lasts CLK_DIV clk cycles.
  - Bits are MSB-first.
- FSM states:
  - IDLE: lasts one cycle after reset release, then goes to CMD.
  - CMD:
    - ss_o=0 on entry; mosi_o = bit 31 of the frame {8'h03, FLASH_BASE} on entry.
    - First SCK rise is CLK_DIV cycles later. After 32 SCK cycles, go to READ.
  - READ:
    - Shift in 32 bits (4 bytes b0..b3, in arrival order), then go to WB_WR.
    - Assembled word is little-endian: {b3,b2,b1,b0}.
    - sck_o stays low at the transition.
  - WB_WR:
    - On entry, drive cyc=stb=we=1, sel=4'hF, adr=IMEM_BASE+4*count, dat=word.
    - All WB outputs stay stable until an edge with wb_ack_i=1 or wb_err_i=1. The next cycle, cyc/stb/we=0.
    - A slave may ack in the first stb cycle.
    - After ack: if count==BOOT_WORDS-1, go to DONE; otherwise count+1 and go to READ.
    - ss_o stays low throughout; no new command is issued.
    - After err: go to ERROR.
  - DONE (terminal until reset): ss_o=1, core_reset_n=1, boot_done=1.
  - ERROR (terminal until reset): ss_o=1, boot_err=1, core_reset_n=0.
- Simultaneous ack and err: err wins.
- Counter width: clog2(BOOT_WORDS). No wrap occurs because the FSM leaves for DONE at BOOT_WORDS-1.
- Minimum time per word: 64*CLK_DIV cycles for READ plus at least 2 cycles for WB_WR.

Optional Feature:
- Macro: BOOT_WB_TIMEOUT_EN.
- Defined: an 8-bit watchdog counts cycles in WB_WR and clears on state entry. If 255 cycles pass without ack or err, the FSM goes to ERROR (boot_err=1, cyc/stb dropped).
- Not defined: no watchdog; WB_WR waits indefinitely.

Decomposition:
- Package boot_loader_pkg holds:
  - the state enum boot_state_t (IDLE, CMD, READ, WB_WR, DONE, ERROR);
  - SPI_READ_CMD=8'h03;
  - WB_TIMEOUT_CYCLES=8'd255.
- Sub-module spi_shift_engine holds:
  - the CLK_DIV divider and a 32-bit shift register;
  - interface: start, tx_word, rx_word, busy, done pulse;
  - drives sck_o/mosi_o and samples miso_i.
- The top level holds the FSM, word counter, Wishbone master and watchdog.

Test Plan:
- Image copy: BOOT_WORDS=4, flash bytes 13 00 00 00 93 00 10 00 13 01 20 00 6f 00 00 00 -> WB writes adr 0x0/0x4/0x8/0xC with dat 0x00000013/0x00100093/0x00200113/0x0000006f. Then boot_done=1, core_reset_n=1, ss_o=1.
- Command frame: FLASH_BASE=24'h010000, flash model captures MOSI -> first 32 bits = 0x03010000. SCK period = 2*CLK_DIV cycles, first rise CLK_DIV cycles after ss_o falls.
- Slow slave: ack delayed 5 cycles on word 1 -> stb held 6 cycles, adr/dat stable, sck_o low throughout, copy completes correctly.
- Slave error: wb_err_i on word 2 -> boot_err=1, core_reset_n=0, ss_o=1, no write to adr 0xC. With ack=err=1 together -> also ERROR.
- Reset mid-READ of word 1: reset_n=0 for one cycle -> next cycle all outputs at reset values. After release, the new CMD frame is seen and the first write is again adr 0x0.
- Watchdog: slave never acks -> with BOOT_WB_TIMEOUT_EN, boot_err=1 exactly 255 cycles after stb rises. Without it, stb still high after 1000 cycles and boot_err=0.
